// File: rtl/mdio_master_if.sv
// mdio_master_if: command/response bundle between a register-access client and
// the Clause-22 MDIO master.
//   cmd_valid/cmd_ready : one-command-at-a-time handshake
//   cmd_write           : 1 = write, 0 = read
//   cmd_phy_addr        : 5-bit PHY address
//   cmd_reg_addr        : 5-bit register address
//   cmd_wdata           : 16-bit write data
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata           : read data (0 after a write)
//   rsp_error           : read turnaround bit 2 sampled high (no PHY answered)
// Modport master is the client side; modport slave is the MDIO master block.
interface mdio_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO management master. Takes one register command at
// a time, generates MDC, serialises the management frame on a split MDIO pin
// and returns read data plus a turnaround error flag as a one-cycle response.
// Ports:
//   clock    : system clock
//   reset    : asynchronous, active-low reset
//   host     : command/response bundle (mdio_master_if.slave)
//   busy     : frame in progress (cycle after handshake through DONE)
//   mdc      : management clock, f_clock / (2*CLOCK_DIVIDE)
//   mdio_o   : MDIO drive value
//   mdio_oe  : MDIO drive enable
//   mdio_i   : MDIO input, already synchronised externally
// Parameters:
//   CLOCK_DIVIDE  : clocks per MDC half-period (>= 2)
//   PREAMBLE_BITS : preamble ones per frame (0 = preamble suppression)
module mdio_master #(
  parameter int CLOCK_DIVIDE  = 20,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic         clock,
  input  logic         reset,
  mdio_master_if.slave host,
  output logic         busy,
  output logic         mdc,
  output logic         mdio_o,
  output logic         mdio_oe,
  input  logic         mdio_i
);

  localparam int               DIV_W    = $clog2(CLOCK_DIVIDE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);
  localparam logic [5:0]       PRE_LAST = (PREAMBLE_BITS > 0) ? 6'(PREAMBLE_BITS - 1) : 6'd0;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    TA,
    DATA,
    DONE
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [31:0]      frame_sr;
  logic             is_write;
  logic [15:0]      rdata_sr;
  logic             ta_error;

  logic [31:0]      new_frame;
  logic             phase_end;

  // Everything after the preamble as one 32-bit word: ST, OP, PHYAD, REGAD,
  // TA, DATA. For reads the TA/DATA positions hold ones so the released line
  // idles high in mdio_o as well.
  always_comb begin
    new_frame = {2'b01,
                 host.cmd_write ? 2'b01 : 2'b10,
                 host.cmd_phy_addr,
                 host.cmd_reg_addr,
                 host.cmd_write ? 2'b10 : 2'b11,
                 host.cmd_write ? host.cmd_wdata : 16'hFFFF};
  end

  assign phase_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      frame_sr       <= '0;
      is_write       <= 1'b0;
      rdata_sr       <= '0;
      ta_error       <= 1'b0;
      busy           <= 1'b0;
      mdc            <= 1'b0;
      mdio_o         <= 1'b1;
      mdio_oe        <= 1'b0;
      host.cmd_ready <= 1'b1;
      host.rsp_valid <= 1'b0;
      host.rsp_rdata <= '0;
      host.rsp_error <= 1'b0;
    end else begin
      host.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (host.cmd_valid && host.cmd_ready) begin
            is_write       <= host.cmd_write;
            rdata_sr       <= '0;
            ta_error       <= 1'b0;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            mdc            <= 1'b0;
            mdio_oe        <= 1'b1;
            busy           <= 1'b1;
            host.cmd_ready <= 1'b0;
            if (PREAMBLE_BITS == 0) begin
              state    <= HEADER;
              mdio_o   <= new_frame[31];
              frame_sr <= {new_frame[30:0], 1'b0};
            end else begin
              state    <= PREAMBLE;
              mdio_o   <= 1'b1;
              frame_sr <= new_frame;
            end
          end
        end

        PREAMBLE, HEADER, TA, DATA: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            mdc     <= ~mdc;
            if (!mdc) begin
              // End of a low phase: the PHY's bit is valid just before mdc rises.
              if (!is_write && state == TA && bit_cnt == 6'd1) begin
                ta_error <= mdio_i;
              end
              if (!is_write && state == DATA) begin
                rdata_sr <= {rdata_sr[14:0], mdio_i};
              end
            end else begin
              // End of a high phase: close this bit and present the next one.
              case (state)
                PREAMBLE: begin
                  if (bit_cnt == PRE_LAST) begin
                    state    <= HEADER;
                    bit_cnt  <= '0;
                    mdio_o   <= frame_sr[31];
                    frame_sr <= {frame_sr[30:0], 1'b0};
                  end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                  end
                end
                HEADER: begin
                  mdio_o   <= frame_sr[31];
                  frame_sr <= {frame_sr[30:0], 1'b0};
                  if (bit_cnt == 6'd13) begin
                    state   <= TA;
                    bit_cnt <= '0;
                    mdio_oe <= is_write;
                  end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                  end
                end
                TA: begin
                  mdio_o   <= frame_sr[31];
                  frame_sr <= {frame_sr[30:0], 1'b0};
                  if (bit_cnt == 6'd1) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                  end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                  end
                end
                default: begin
                  if (bit_cnt == 6'd15) begin
                    state          <= DONE;
                    bit_cnt        <= '0;
                    mdio_oe        <= 1'b0;
                    mdio_o         <= 1'b1;
                    host.rsp_valid <= 1'b1;
                    host.rsp_rdata <= is_write ? 16'h0000 : rdata_sr;
                    host.rsp_error <= is_write ? 1'b0 : ta_error;
                  end else begin
                    mdio_o   <= frame_sr[31];
                    frame_sr <= {frame_sr[30:0], 1'b0};
                    bit_cnt  <= bit_cnt + 6'd1;
                  end
                end
              endcase
            end
          end
        end

        DONE: begin
          state          <= IDLE;
          busy           <= 1'b0;
          host.cmd_ready <= 1'b1;
        end

        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          mdc            <= 1'b0;
          mdio_oe        <= 1'b0;
          mdio_o         <= 1'b1;
          host.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: scoreboard bench for mdio_master. Two instances are built:
// dut_a with the default timing (CLOCK_DIVIDE=20, PREAMBLE_BITS=32) and dut_b
// with CLOCK_DIVIDE=2, PREAMBLE_BITS=0; 'sel' picks which one is driven and
// watched. Expected bit streams, PHY behaviour and responses are queued when a
// command is presented and consumed as the frame runs.
// Cycle numbering: a handshake sampled at edge k counts the cycle that follows
// it as k+1, so a response raised at edge m occupies cycle m+1.
module tb_mdio_master;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt = edge_cnt + 1;

  mdio_master_if if_a();
  mdio_master_if if_b();

  logic busy_a, mdc_a, mdio_o_a, mdio_oe_a;
  logic busy_b, mdc_b, mdio_o_b, mdio_oe_b;
  logic phy_mdio;

  logic        sel;
  logic        cmd_valid;
  logic        cmd_write;
  logic [4:0]  cmd_phy;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;

  assign if_a.cmd_valid    = cmd_valid & ~sel;
  assign if_a.cmd_write    = cmd_write;
  assign if_a.cmd_phy_addr = cmd_phy;
  assign if_a.cmd_reg_addr = cmd_reg;
  assign if_a.cmd_wdata    = cmd_wdata;
  assign if_b.cmd_valid    = cmd_valid & sel;
  assign if_b.cmd_write    = cmd_write;
  assign if_b.cmd_phy_addr = cmd_phy;
  assign if_b.cmd_reg_addr = cmd_reg;
  assign if_b.cmd_wdata    = cmd_wdata;

  mdio_master #(.CLOCK_DIVIDE(20), .PREAMBLE_BITS(32)) dut_a (
    .clock(clock), .reset(reset), .host(if_a.slave), .busy(busy_a),
    .mdc(mdc_a), .mdio_o(mdio_o_a), .mdio_oe(mdio_oe_a), .mdio_i(phy_mdio)
  );

  mdio_master #(.CLOCK_DIVIDE(2), .PREAMBLE_BITS(0)) dut_b (
    .clock(clock), .reset(reset), .host(if_b.slave), .busy(busy_b),
    .mdc(mdc_b), .mdio_o(mdio_o_b), .mdio_oe(mdio_oe_b), .mdio_i(phy_mdio)
  );

  logic        cmd_ready_m, rsp_valid_m, rsp_error_m, busy_m, mdc_m, mdio_o_m, mdio_oe_m;
  logic [15:0] rsp_rdata_m;
  assign cmd_ready_m = sel ? if_b.cmd_ready : if_a.cmd_ready;
  assign rsp_valid_m = sel ? if_b.rsp_valid : if_a.rsp_valid;
  assign rsp_rdata_m = sel ? if_b.rsp_rdata : if_a.rsp_rdata;
  assign rsp_error_m = sel ? if_b.rsp_error : if_a.rsp_error;
  assign busy_m      = sel ? busy_b    : busy_a;
  assign mdc_m       = sel ? mdc_b     : mdc_a;
  assign mdio_o_m    = sel ? mdio_o_b  : mdio_o_a;
  assign mdio_oe_m   = sel ? mdio_oe_b : mdio_oe_a;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  typedef struct {
    logic oe;
    logic val;
  } bit_t;

  typedef struct {
    logic        present;
    logic [15:0] data;
    int          pre;
  } phy_t;

  rsp_t exp_rsp_q[$];
  bit_t exp_bit_q[$];
  phy_t phy_q[$];
  int   hs_edge_q[$];

  int   cur_d;
  int   cur_p;
  phy_t cur_phy;
  int   phy_bit;
  int   hs_count;
  int   last_hs_edge;
  int   last_rsp_edge;
  int   last_change;
  logic mdc_prev;
  logic rsp_check_next;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp_v);
    end
  endtask

  // What a well-behaved PHY (or an empty bus with pull-up) puts on MDIO for frame bit b.
  function automatic logic phyValue(input int b);
    int first_ta2;
    first_ta2 = cur_phy.pre + 15;
    if (!cur_phy.present) return 1'b1;
    if (b == first_ta2) return 1'b0;
    if (b > first_ta2 && b <= first_ta2 + 16) return cur_phy.data[15 - (b - first_ta2 - 1)];
    return 1'b1;
  endfunction

  // Present a command and queue everything the frame is expected to produce.
  task automatic applyStimulus(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                               input logic [15:0] wd, input logic present, input logic [15:0] pdata);
    logic [31:0] fr;
    bit_t        b;
    rsp_t        r;
    phy_t        p;
    cmd_write = wr;
    cmd_phy   = phy;
    cmd_reg   = rg;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    fr = {2'b01, wr ? 2'b01 : 2'b10, phy, rg, 2'b10, wd};
    for (int i = 0; i < cur_p; i++) begin
      b.oe = 1'b1; b.val = 1'b1;
      exp_bit_q.push_back(b);
    end
    for (int i = 0; i < 32; i++) begin
      b.oe  = wr | (i < 14);
      b.val = fr[31 - i];
      exp_bit_q.push_back(b);
    end
    p.present = present; p.data = pdata; p.pre = cur_p;
    phy_q.push_back(p);
    if (wr) begin
      r.rdata = 16'h0000; r.err = 1'b0;
    end else if (present) begin
      r.rdata = pdata; r.err = 1'b0;
    end else begin
      r.rdata = 16'hFFFF; r.err = 1'b1;
    end
    r.lat = 2 * cur_d * (cur_p + 32) + 1;
    exp_rsp_q.push_back(r);
  endtask

  task automatic waitHandshake(input int budget);
    int start;
    logic got;
    start = hs_count;
    got   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (hs_count != start) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("handshake_seen", 32'(got), 32'd1);
  endtask

  task automatic dropValid();
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (exp_rsp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("frame_done", 32'(done), 32'd1);
    repeat (3) @(negedge clock);
  endtask

  task automatic checkIdleOutputs(input string who);
    checkOutput({who, "_cmd_ready"}, 32'(cmd_ready_m), 32'd1);
    checkOutput({who, "_busy"},      32'(busy_m),      32'd0);
    checkOutput({who, "_mdc"},       32'(mdc_m),       32'd0);
    checkOutput({who, "_mdio_oe"},   32'(mdio_oe_m),   32'd0);
    checkOutput({who, "_mdio_o"},    32'(mdio_o_m),    32'd1);
    checkOutput({who, "_rsp_valid"}, 32'(rsp_valid_m), 32'd0);
  endtask

  // Monitor: handshakes, MDC edges (timing, bit stream, PHY drive) and responses.
  always @(negedge clock) begin
    bit_t b;
    rsp_t r;
    int   hs;
    if (reset !== 1'b1) begin
      mdc_prev       = 1'b0;
      rsp_check_next = 1'b0;
    end else begin
      if (rsp_check_next) begin
        checkOutput("rsp_pulse_width", 32'(rsp_valid_m), 32'd0);
        checkOutput("ready_after_rsp", 32'(cmd_ready_m), 32'd1);
        rsp_check_next = 1'b0;
      end
      if (cmd_valid && cmd_ready_m) begin
        last_hs_edge = edge_cnt + 1;
        hs_edge_q.push_back(last_hs_edge);
        hs_count++;
        last_change = last_hs_edge;
        if (phy_q.size() > 0) cur_phy = phy_q.pop_front();
        else checkOutput("phy_queue_empty", 32'd1, 32'd0);
        phy_bit  = 0;
        phy_mdio = phyValue(0);
      end
      if (mdc_m !== mdc_prev) begin
        checkOutput("mdc_half_period", 32'(edge_cnt - last_change), 32'(cur_d));
        last_change = edge_cnt;
        if (mdc_m) begin
          if (exp_bit_q.size() == 0) begin
            checkOutput("unexpected_mdc_bit", 32'd1, 32'd0);
          end else begin
            b = exp_bit_q.pop_front();
            checkOutput($sformatf("bit%0d_oe", phy_bit), 32'(mdio_oe_m), 32'(b.oe));
            if (b.oe) checkOutput($sformatf("bit%0d_val", phy_bit), 32'(mdio_o_m), 32'(b.val));
          end
        end else begin
          phy_bit++;
          phy_mdio = phyValue(phy_bit);
        end
      end
      mdc_prev = mdc_m;
      if (rsp_valid_m) begin
        if (exp_rsp_q.size() == 0 || hs_edge_q.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          r  = exp_rsp_q.pop_front();
          hs = hs_edge_q.pop_front();
          checkOutput("rsp_rdata",   32'(rsp_rdata_m),         32'(r.rdata));
          checkOutput("rsp_error",   32'(rsp_error_m),         32'(r.err));
          checkOutput("rsp_latency", 32'(edge_cnt + 1 - hs),   32'(r.lat));
          checkOutput("busy_at_done", 32'(busy_m),             32'd1);
        end
        last_rsp_edge  = edge_cnt;
        rsp_check_next = 1'b1;
      end
    end
  end

  initial begin
    sel       = 1'b0;
    cur_d     = 20;
    cur_p     = 32;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_phy   = '0;
    cmd_reg   = '0;
    cmd_wdata = '0;
    phy_mdio  = 1'b1;
    phy_bit   = 0;
    hs_count  = 0;
    last_hs_edge  = 0;
    last_rsp_edge = 0;
    last_change   = 0;
    mdc_prev      = 1'b0;
    rsp_check_next = 1'b0;
    cur_phy.present = 1'b0; cur_phy.data = '0; cur_phy.pre = 32;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    checkIdleOutputs("reset_a");
    checkOutput("reset_a_rdata", 32'(rsp_rdata_m), 32'd0);
    checkOutput("reset_a_error", 32'(rsp_error_m), 32'd0);
    sel = 1'b1;
    #1;
    checkIdleOutputs("reset_b");
    checkOutput("reset_b_rdata", 32'(rsp_rdata_m), 32'd0);
    checkOutput("reset_b_error", 32'(rsp_error_m), 32'd0);
    sel = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    $display("[TB] write PHY 0x01 reg 0x00 data 0x8000");
    applyStimulus(1'b1, 5'h01, 5'h00, 16'h8000, 1'b0, 16'h0000);
    waitHandshake(20);
    dropValid();
    waitDone(4000);

    $display("[TB] read PHY 0x03 reg 0x01, PHY answers 0x796D");
    @(posedge clock); #1;
    applyStimulus(1'b0, 5'h03, 5'h01, 16'h0000, 1'b1, 16'h796D);
    waitHandshake(20);
    dropValid();
    waitDone(4000);

    $display("[TB] read with no PHY on the bus");
    @(posedge clock); #1;
    applyStimulus(1'b0, 5'h05, 5'h02, 16'h0000, 1'b0, 16'h0000);
    waitHandshake(20);
    dropValid();
    waitDone(4000);

    $display("[TB] back-to-back write then read with cmd_valid held");
    @(posedge clock); #1;
    applyStimulus(1'b1, 5'h1F, 5'h1F, 16'hA5C3, 1'b0, 16'h0000);
    waitHandshake(20);
    repeat (300) @(posedge clock);
    #1;
    applyStimulus(1'b0, 5'h02, 5'h11, 16'h5A5A, 1'b1, 16'h1234);
    waitHandshake(4000);
    checkOutput("second_hs_after_rsp", 32'(last_hs_edge - last_rsp_edge), 32'd2);
    dropValid();
    waitDone(4000);

    $display("[TB] reset during bit 40 of a write");
    @(posedge clock); #1;
    applyStimulus(1'b1, 5'h00, 5'h1F, 16'hFFFF, 1'b0, 16'h0000);
    waitHandshake(20);
    dropValid();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (phy_bit >= 40) break;
    end
    checkOutput("reached_bit40", 32'(phy_bit >= 40), 32'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checkIdleOutputs("abort");
    exp_bit_q.delete();
    exp_rsp_q.delete();
    phy_q.delete();
    hs_edge_q.delete();
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    repeat (200) @(negedge clock);
    @(posedge clock); #1;
    applyStimulus(1'b0, 5'h07, 5'h03, 16'h0000, 1'b1, 16'hC3A5);
    waitHandshake(20);
    dropValid();
    waitDone(4000);

    $display("[TB] preamble suppressed, CLOCK_DIVIDE=2");
    sel   = 1'b1;
    cur_d = 2;
    cur_p = 0;
    @(posedge clock); #1;
    applyStimulus(1'b1, 5'h12, 5'h05, 16'hBEEF, 1'b0, 16'h0000);
    waitHandshake(20);
    dropValid();
    waitDone(400);
    @(posedge clock); #1;
    applyStimulus(1'b0, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h0F0F);
    waitHandshake(20);
    dropValid();
    waitDone(400);

    checkOutput("leftover_bits", 32'(exp_bit_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Clause-22 MDIO management master; the NIC control plane uses it to read and write PHY registers (link status, autonegotiation, reset).
- Accepts one register command at a time over a valid/ready handshake.
- Generates MDC and serialises the management frame on a split MDIO pin (o/oe/i).
- Returns read data and a turnaround error flag as a single-cycle response pulse.

Parameters:
- CLOCK_DIVIDE, 20, clocks per MDC half-period; MDC = f_clock / (2*CLOCK_DIVIDE); legal range >= 2.
- PREAMBLE_BITS, 32, number of preamble '1' bits per frame; 0 = preamble suppression.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block idle and able to accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_phy_addr  input  5  PHY address
- cmd_reg_addr  input  5  register address
- cmd_wdata  input  16  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  16  read data; 0 for writes
- rsp_error  output  1  read turnaround bit 2 sampled as 1 (no PHY response)
- busy  output  1  frame in progress
- mdc  output  1  management clock
- mdio_o  output  1  MDIO drive value
- mdio_oe  output  1  MDIO drive enable
- mdio_i  input  1  MDIO sampled value (already synchronised externally)

Behaviour:
- Reset (asynchronous, reset=0), applied immediately:
  - state=IDLE; mdc=0, mdio_oe=0, mdio_o=1
  - cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_error=0
  - counters cleared
- Reset asserted mid-frame aborts the frame; no rsp_valid is issued for it.
- Handshake:
  - cmd_ready = (state==IDLE).
  - Command is captured on a clock edge where cmd_valid & cmd_ready; all cmd_* fields are latched there.
  - cmd_* is ignored while busy; cmd_valid held high across completion is accepted on the first cycle cmd_ready=1.
- Frame: PREAMBLE_BITS ones, ST=01, OP (01 write / 10 read), PHYAD[4:0] MSB first, REGAD[4:0] MSB first, TA (2 bits), DATA[15:0] MSB first. Total bits = PREAMBLE_BITS+32.
- MDC timing:
  - Each bit period = CLOCK_DIVIDE clocks low, then CLOCK_DIVIDE clocks high.
  - The first low phase starts in the clock after the handshake.
  - mdc is registered.
  - mdio_o/mdio_oe change only at the start of a low phase; they are stable through the following rising edge.
- Read direction:
  - TA and DATA bits: mdio_oe=0.
  - mdio_i is sampled in the last clock of each low phase, just before mdc rises.
  - TA bit 2 sample != 0 sets rsp_error=1. The frame still completes and data is still captured.
- Write direction: mdio_oe=1 for the whole frame; TA driven as 1,0.
- State machine:
  - IDLE -> PREAMBLE on handshake, or directly -> HEADER if PREAMBLE_BITS=0.
  - PREAMBLE -> HEADER after PREAMBLE_BITS bit periods.
  - HEADER (14 bits: ST, OP, PHYAD, REGAD) -> TA (2 bits) -> DATA (16 bits) -> DONE.
  - DONE lasts one clock: mdc=0, mdio_oe=0, mdio_o=1, rsp_valid=1.
  - DONE -> IDLE.
  - Transitions occur at the end of a high phase.
  - A 6-bit bit counter plus a half-period divider counter sized by $clog2(CLOCK_DIVIDE) are used.
- Latency: handshake at edge k -> rsp_valid high during cycle k + 2*CLOCK_DIVIDE*(PREAMBLE_BITS+32) + 1. cmd_ready returns in the following cycle.
- busy=1 from the cycle after the handshake through DONE inclusive.
- rsp_rdata/rsp_error are held after rsp_valid until the next completion. For writes they are cleared to 0 at DONE.
- Idle line: mdc=0, mdio_oe=0.

Test Plan:
- Write, PHY 0x01, reg 0x00, data 0x8000 -> on rising mdc edges, mdio_o sequence is 32x'1', 0101, 00001, 00000, 10, 1000000000000000; mdio_oe=1 throughout; rsp_valid at k+2561 (D=20); rsp_rdata=0, rsp_error=0.
- Read, PHY 0x03, reg 0x01; bench PHY drives TA2=0 and data 0x796D -> mdio_oe falls at start of TA; rsp_rdata=0x796D, rsp_error=0; one-cycle rsp_valid.
- Read with mdio_i held 1 (no PHY) -> rsp_error=1, rsp_rdata=0xFFFF, frame length unchanged.
- cmd_valid held high for two commands (write then read) -> second handshake in cycle after rsp_valid; a new cmd_wdata presented mid-frame does not corrupt the first frame.
- reset driven low at bit 40 of a write -> mdc=0, mdio_oe=0, busy=0 immediately; no rsp_valid; after release a new read completes normally.
- PREAMBLE_BITS=0, CLOCK_DIVIDE=2 -> frame starts with ST; rsp_valid at k+129; mdc period 4 clocks.
